// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, MEM-stage FSM states and access sizing.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memState_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } accSize_t;

  function automatic accSize_t opSize(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: opSize = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: opSize = SZ_HALF;
      default:              opSize = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data-memory port: store enables/replication,
// load extraction with sign/zero extension, and alignment checking.
module mem_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  addrLow,
  input  logic [31:0] storeData,
  input  logic [31:0] readData,
  output logic [3:0]  byteEn,
  output logic [31:0] writeData,
  output logic [31:0] loadData,
  output logic        misalign
);

  accSize_t    size;
  logic        signExt;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  always_comb begin
    size     = opSize(opcode);
    signExt  = (opcode == OP_LB) || (opcode == OP_LH);
    laneHalf = addrLow[1] ? readData[31:16] : readData[15:0];
    case (addrLow)
      2'd0:    laneByte = readData[7:0];
      2'd1:    laneByte = readData[15:8];
      2'd2:    laneByte = readData[23:16];
      default: laneByte = readData[31:24];
    endcase

    byteEn    = 4'b1111;
    writeData = storeData;
    loadData  = readData;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteEn    = 4'b0001 << addrLow;
        writeData = {4{storeData[7:0]}};
        loadData  = {{24{signExt & laneByte[7]}}, laneByte};
      end
      SZ_HALF: begin
        misalign  = addrLow[0];
        byteEn    = addrLow[1] ? 4'b1100 : 4'b0011;
        writeData = {2{storeData[15:0]}};
        loadData  = {{16{signExt & laneHalf[15]}}, laneHalf};
      end
      default: begin
        misalign  = |addrLow;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with data-memory req/ready handshake, wait timeout and MEM/WB register.
//   state   | meaning
//   ST_IDLE | no access outstanding; a new aligned access raises dmem_req this cycle
//   ST_WAIT | access issued, waiting for dmem_ready; upstream frozen by oStall
module mem_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        iRegWrite,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iMemToReg,
  input  logic [31:0] iIR,
  input  logic [31:0] iPC,
  input  logic [31:0] iB,
  input  logic [31:0] iResult,
  input  logic [4:0]  iRegDest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        oStall,
  output logic        oRegWrite,
  output logic        oMemToReg,
  output logic [4:0]  oRegDest,
  output logic [31:0] oPC,
  output logic [31:0] oIR,
  output logic [31:0] oResult,
  output logic [31:0] oReadData,
  output logic        oMisalign,
  output logic        oBusErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  memState_t   state, nextState;
  logic [CW-1:0] waitCount;
  logic        access, misalign, reqActive, complete, timeoutHit;
  logic [3:0]  byteEn;
  logic [31:0] writeData, loadData;

  assign access    = iMemRead | iMemWrite;
  assign reqActive = access & ~misalign;

  mem_align uAlign (
    .opcode    (iIR[31:26]),
    .addrLow   (iResult[1:0]),
    .storeData (iB),
    .readData  (dmem_rdata),
    .byteEn    (byteEn),
    .writeData (writeData),
    .loadData  (loadData),
    .misalign  (misalign)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (reqActive && !dmem_ready) nextState = ST_WAIT;
      ST_WAIT: if (dmem_ready || timeoutHit || !reqActive) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Outputs are gated by resetn so the bus is quiet for the whole reset period.
  always_comb begin
    timeoutHit = (state == ST_WAIT) && (waitCount == CW'(TIMEOUT - 1)) && !dmem_ready && reqActive;
    complete   = reqActive && dmem_ready;
    dmem_req   = resetn && reqActive;
    oStall     = resetn && reqActive && !dmem_ready && !timeoutHit;
    dmem_we    = dmem_req && iMemWrite && !iMemRead;
    dmem_addr  = dmem_req ? {iResult[31:2], 2'b00} : 32'h0;
    dmem_be    = dmem_req ? byteEn : 4'b0000;
    dmem_wdata = dmem_req ? writeData : 32'h0;
  end

  // Counts total request cycles, including the initial IDLE cycle.
  always_ff @(posedge clock) begin
    if (!resetn)                                   waitCount <= '0;
    else if (state == ST_IDLE)                     waitCount <= (reqActive && !dmem_ready) ? CW'(1) : '0;
    else if (dmem_ready || timeoutHit || !reqActive) waitCount <= '0;
    else                                           waitCount <= waitCount + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      oRegWrite <= 1'b0;
      oMemToReg <= 1'b0;
      oRegDest  <= '0;
      oPC       <= '0;
      oIR       <= '0;
      oResult   <= '0;
      oReadData <= '0;
      oMisalign <= 1'b0;
      oBusErr   <= 1'b0;
    end else begin
      oRegDest  <= iRegDest;
      oPC       <= iPC;
      oResult   <= iResult;
      oMisalign <= access && misalign;
      oBusErr   <= timeoutHit;
      if (oStall || timeoutHit || (access && misalign)) begin
        oRegWrite <= 1'b0;
        oMemToReg <= 1'b0;
        oIR       <= '0;
        oReadData <= '0;
      end else begin
        oRegWrite <= iRegWrite;
        oMemToReg <= iMemToReg;
        oIR       <= iIR;
        oReadData <= (complete && iMemRead) ? loadData : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random instructions
// checked against a per-instruction behavioural model of the memory access.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        iRegWrite, iMemRead, iMemWrite, iMemToReg;
  logic [31:0] iIR, iPC, iB, iResult;
  logic [4:0]  iRegDest;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        oStall, oRegWrite, oMemToReg, oMisalign, oBusErr;
  logic [4:0]  oRegDest;
  logic [31:0] oPC, oIR, oResult, oReadData;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn),
    .iRegWrite(iRegWrite), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
    .iIR(iIR), .iPC(iPC), .iB(iB), .iResult(iResult), .iRegDest(iRegDest),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .oStall(oStall), .oRegWrite(oRegWrite), .oMemToReg(oMemToReg), .oRegDest(oRegDest),
    .oPC(oPC), .oIR(oIR), .oResult(oResult), .oReadData(oReadData),
    .oMisalign(oMisalign), .oBusErr(oBusErr)
  );

  task automatic setIdle();
    iRegWrite = 0; iMemRead = 0; iMemWrite = 0; iMemToReg = 0;
    iIR = 0; iPC = 0; iB = 0; iResult = 0; iRegDest = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  function automatic int sizeOf(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      default:             return 4;
    endcase
  endfunction

  // Drives one instruction until it leaves MEM; waitN = cycles before dmem_ready (>=TO: never).
  task automatic runInstr(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] b,
                          input logic [31:0] rdata, input int waitN, input logic rw,
                          output int stalls, output logic [31:0] gotRead);
    logic isLoad, isStore, access, mis, active, done, expStall, abort, bubble, finished;
    int sz, sgn;
    logic [31:0] expWd, expLoad, sh, expIR, expRD;
    logic [3:0] expBe;
    isLoad  = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    isStore = op inside {6'h28, 6'h29, 6'h2B};
    access  = isLoad | isStore;
    iMemRead = isLoad; iMemWrite = isStore; iMemToReg = isLoad; iRegWrite = rw;
    iIR = {op, 26'($urandom)}; iPC = $urandom; iB = b; iResult = addr; iRegDest = 5'($urandom);
    sz  = sizeOf(op);
    sgn = (op == 6'h20 || op == 6'h21) ? 1 : 0;
    mis = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'd0);
    active = access && !mis;
    expBe = 4'(((1 << sz) - 1) << addr[1:0]);
    if (sz == 1)      expWd = {24'h0, b[7:0]} * 32'h01010101;
    else if (sz == 2) expWd = {16'h0, b[15:0]} * 32'h00010001;
    else              expWd = b;
    sh = rdata >> (8 * addr[1:0]);
    if (sz == 1) begin
      expLoad = sh & 32'hFF;
      if (sgn == 1 && expLoad >= 32'h80) expLoad = expLoad | 32'hFFFFFF00;
    end else if (sz == 2) begin
      expLoad = sh & 32'hFFFF;
      if (sgn == 1 && expLoad >= 32'h8000) expLoad = expLoad | 32'hFFFF0000;
    end else expLoad = rdata;
    stalls = 0; gotRead = 32'h0; finished = 0;
    for (int c = 0; c < TO + 2; c++) begin
      dmem_ready = (c == waitN);
      dmem_rdata = dmem_ready ? rdata : $urandom;
      #1;
      done = !active || c == waitN || c == TO - 1;
      expStall = active && !done;
      checks++;
      if (dmem_req !== active) begin errors++; $display("FAIL req cyc%0d got %b exp %b", c, dmem_req, active); end
      checks++;
      if (oStall !== expStall) begin errors++; $display("FAIL stall cyc%0d got %b exp %b", c, oStall, expStall); end
      if (active) begin
        checks++;
        if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== isStore) begin
          errors++; $display("FAIL addr/we got %h/%b exp %h/%b", dmem_addr, dmem_we, {addr[31:2], 2'b00}, isStore);
        end
        if (isStore) begin
          checks++;
          if (dmem_be !== expBe || dmem_wdata !== expWd) begin
            errors++; $display("FAIL store lanes got be %b wd %h exp be %b wd %h", dmem_be, dmem_wdata, expBe, expWd);
          end
        end
      end
      @(posedge clock); #1;
      if (expStall) begin
        stalls++;
        checks++;
        if (oRegWrite !== 1'b0 || oMemToReg !== 1'b0 || oIR !== 32'h0) begin
          errors++; $display("FAIL stall bubble got rw %b mtr %b ir %h exp 0", oRegWrite, oMemToReg, oIR);
        end
      end else begin
        abort  = active && c != waitN;
        bubble = (access && mis) || abort;
        expIR  = bubble ? 32'h0 : iIR;
        expRD  = (active && !abort && isLoad) ? expLoad : 32'h0;
        checks++;
        if (oMisalign !== (access && mis) || oBusErr !== abort) begin
          errors++; $display("FAIL pulses got mis %b berr %b exp %b %b", oMisalign, oBusErr, access && mis, abort);
        end
        checks++;
        if (oRegWrite !== (bubble ? 1'b0 : rw) || oMemToReg !== (bubble ? 1'b0 : isLoad) || oIR !== expIR) begin
          errors++; $display("FAIL memwb ctl got rw %b mtr %b ir %h exp ir %h", oRegWrite, oMemToReg, oIR, expIR);
        end
        checks++;
        if (oReadData !== expRD) begin errors++; $display("FAIL readdata got %h exp %h", oReadData, expRD); end
        gotRead = oReadData;
        finished = 1;
        break;
      end
    end
    if (!finished) begin errors++; $display("FAIL instr did not retire within budget"); end
    setIdle();
  endtask

  task automatic test_reset();
    setIdle();
    iMemRead = 1; iIR = {6'h23, 26'h0}; iResult = 32'h40;
    resetn = 0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (dmem_req !== 0 || oStall !== 0 || oRegWrite !== 0 || oReadData !== 0 || oPC !== 0 || oIR !== 0
        || oBusErr !== 0 || oMisalign !== 0) begin
      errors++; $display("FAIL reset state got req %b stall %b rw %b rd %h", dmem_req, oStall, oRegWrite, oReadData);
    end
    setIdle();
    resetn = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_lw_zero_wait();
    int st; logic [31:0] rd;
    runInstr(6'h23, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b1, st, rd);
    checks++;
    if (st !== 0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw0 got st %0d rd %h exp 0 deadbeef", st, rd); end
  endtask

  task automatic test_lb_wait();
    int st; logic [31:0] rd;
    runInstr(6'h20, 32'h13, 32'h0, 32'h80FFFFFF, 3, 1'b1, st, rd);
    checks++;
    if (st !== 3 || rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got st %0d rd %h exp 3 ffffff80", st, rd); end
    runInstr(6'h24, 32'h13, 32'h0, 32'h80FFFFFF, 3, 1'b1, st, rd);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu got %h exp 00000080", rd); end
  endtask

  task automatic test_sh_store();
    int st; logic [31:0] rd;
    iIR = {6'h29, 26'h0}; iMemWrite = 1; iB = 32'h1234ABCD; iResult = 32'h22;
    #1;
    checks++;
    if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCDABCD || dmem_we !== 1'b1) begin
      errors++; $display("FAIL sh lanes got be %b wd %h we %b", dmem_be, dmem_wdata, dmem_we);
    end
    runInstr(6'h29, 32'h22, 32'h1234ABCD, 32'h0, 2, 1'b0, st, rd);
    checks++;
    if (st !== 2) begin errors++; $display("FAIL sh stalls got %0d exp 2", st); end
  endtask

  task automatic test_misalign();
    int st; logic [31:0] rd;
    runInstr(6'h23, 32'h06, 32'h0, 32'h11223344, 0, 1'b1, st, rd);
    checks++;
    if (oMisalign !== 1'b1 || oRegWrite !== 1'b0 || st !== 0) begin
      errors++; $display("FAIL lw misalign got mis %b rw %b st %0d", oMisalign, oRegWrite, st);
    end
    runInstr(6'h21, 32'h101, 32'h0, 32'h11223344, 0, 1'b1, st, rd);
    @(posedge clock); #1;
    checks++;
    if (oMisalign !== 1'b0) begin errors++; $display("FAIL misalign pulse width got %b exp 0", oMisalign); end
  endtask

  task automatic test_timeout();
    int st; logic [31:0] rd;
    runInstr(6'h23, 32'h80, 32'h0, 32'h0, TO, 1'b1, st, rd);
    checks++;
    if (st !== TO - 1 || oBusErr !== 1'b1) begin errors++; $display("FAIL timeout got st %0d berr %b exp %0d 1", st, oBusErr, TO - 1); end
    #1;
    checks++;
    if (dmem_req !== 0 || oStall !== 0) begin errors++; $display("FAIL post-timeout idle got req %b stall %b", dmem_req, oStall); end
    @(posedge clock); #1;
    checks++;
    if (oBusErr !== 1'b0) begin errors++; $display("FAIL buserr pulse width got %b exp 0", oBusErr); end
  endtask

  task automatic test_reset_mid_wait();
    int st; logic [31:0] rd;
    iMemRead = 1; iMemToReg = 1; iRegWrite = 1; iIR = {6'h23, 26'h5}; iResult = 32'h44; iPC = 32'h100;
    dmem_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (oStall !== 1'b1) begin errors++; $display("FAIL wait entry got stall %b exp 1", oStall); end
    resetn = 0;
    @(posedge clock); #1;
    checks++;
    if (dmem_req !== 0 || oStall !== 0 || oRegWrite !== 0 || oMemToReg !== 0 || oPC !== 0 || oIR !== 0
        || oResult !== 0 || oRegDest !== 0 || oReadData !== 0 || oBusErr !== 0) begin
      errors++; $display("FAIL reset mid-wait got req %b stall %b pc %h res %h", dmem_req, oStall, oPC, oResult);
    end
    setIdle();
    resetn = 1;
    @(posedge clock); #1;
    runInstr(6'h23, 32'h48, 32'h0, 32'hCAFEF00D, 2, 1'b1, st, rd);
    checks++;
    if (st !== 2 || rd !== 32'hCAFEF00D) begin errors++; $display("FAIL after reset got st %0d rd %h", st, rd); end
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    int st; logic [31:0] rd;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h08};
    for (int n = 0; n < 120; n++) begin
      runInstr(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
               int'($urandom_range(0, TO)), 1'($urandom), st, rd);
    end
  endtask

  initial begin
    setIdle();
    test_reset();
    test_lw_zero_wait();
    test_lb_wait();
    test_sh_store();
    test_misalign();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
